pipelined_memory: RTL

Parametrised, handshaked successor to the single-cycle unified memory: one data port (load/store, all MIPS access widths including unaligned left/right) plus one instruction-fetch port sharing a byte-lane block RAM. Sits between the CPU load/store stage and fetch stage. Adds valid/ready backpressure on the data port, a registered pipeline stage, deterministic store-to-fetch forwarding and optional alignment trapping.

---
 rtl/pipelined_memory_pkg.sv | 63 ++++++
 rtl/pipelined_memory_byte_lane_ram.sv | 38 +++
 rtl/pipelined_memory.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipelined_memory_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_memory_pkg
// Memory access mode definitions shared between the CPU load/store logic and
// pipelined_memory.
//   ReadWriteMode_t  : access width / MIPS unaligned left-right selector
//   laneMask()       : byte lanes touched by a store of a given mode/offset
//   storeShift()     : moves store data onto the lanes given by laneMask()
//   alignOffset()    : byte offset with the ignored low bits cleared
//   isMisaligned()   : HALFWORD/WORD access whose low bits are not zero
// -----------------------------------------------------------------------------
package pipelined_memory_pkg;

   typedef enum logic [2:0] {
      ReadWriteMode_NONE,
      ReadWriteMode_BYTE,
      ReadWriteMode_HALFWORD,
      ReadWriteMode_WORD,
      ReadWriteMode_WORDLEFT,
      ReadWriteMode_WORDRIGHT
   } ReadWriteMode_t;

   localparam int LANE_COUNT = 4;

   // WORDLEFT covers lanes 0..k, WORDRIGHT covers lanes k..3.
   function automatic logic [3:0] laneMask(input ReadWriteMode_t mode, input logic [1:0] offset);
      case (mode)
         ReadWriteMode_BYTE:      laneMask = 4'b0001 << offset;
         ReadWriteMode_HALFWORD:  laneMask = offset[1] ? 4'b1100 : 4'b0011;
         ReadWriteMode_WORD:      laneMask = 4'b1111;
         ReadWriteMode_WORDLEFT:  laneMask = 4'b1111 >> (2'd3 - offset);
         ReadWriteMode_WORDRIGHT: laneMask = 4'b1111 << offset;
         default:                 laneMask = 4'b0000;
      endcase
   endfunction

   // WORDLEFT stores the top k+1 bytes of the register, so data moves down.
   function automatic logic [31:0] storeShift(input ReadWriteMode_t mode, input logic [1:0] offset,
                                              input logic [31:0] data);
      logic [4:0] sh;
      sh = {offset, 3'b000};
      case (mode)
         ReadWriteMode_BYTE,
         ReadWriteMode_WORDRIGHT: storeShift = data << sh;
         ReadWriteMode_HALFWORD:  storeShift = data << {offset[1], 4'b0000};
         ReadWriteMode_WORDLEFT:  storeShift = data >> (5'd24 - sh);
         default:                 storeShift = data;
      endcase
   endfunction

   function automatic logic [1:0] alignOffset(input ReadWriteMode_t mode, input logic [1:0] offset);
      case (mode)
         ReadWriteMode_HALFWORD: alignOffset = {offset[1], 1'b0};
         ReadWriteMode_WORD:     alignOffset = 2'b00;
         default:                alignOffset = offset;
      endcase
   endfunction

   function automatic logic isMisaligned(input ReadWriteMode_t mode, input logic [1:0] offset);
      isMisaligned = ((mode == ReadWriteMode_HALFWORD) && offset[0]) ||
                     ((mode == ReadWriteMode_WORD) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/pipelined_memory_byte_lane_ram.sv
// -----------------------------------------------------------------------------
// pipelined_memory_byte_lane_ram
// Word-organised RAM with four byte lanes, for block-RAM inference.
//   Port A: enabled read/write, per-lane write enables, read-before-write
//           (aReadData shows the word as it was before the same-edge write)
//           and aReadData holds while aEnable is low.
//   Port B: read-only, registered every cycle.
//   INIT_FILE: image name parameter; contents start undefined.
// -----------------------------------------------------------------------------
module pipelined_memory_byte_lane_ram #(
   parameter int    ADDR_BITS = 14,
   parameter string INIT_FILE = ""
) (
   input  logic                 clk,
   input  logic                 aEnable,
   input  logic [3:0]           aWriteEnable,
   input  logic [ADDR_BITS-1:0] aAddress,
   input  logic [31:0]          aWriteData,
   output logic [31:0]          aReadData,
   input  logic [ADDR_BITS-1:0] bAddress,
   output logic [31:0]          bReadData
);

   logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

   always_ff @(posedge clk) begin
      if (aEnable) begin
         aReadData <= mem[aAddress];
         for (int i = 0; i < 4; i++) begin
            if (aWriteEnable[i]) begin
               mem[aAddress][8*i +: 8] <= aWriteData[8*i +: 8];
            end
         end
      end
      bReadData <= mem[bAddress];
   end

endmodule

// File: rtl/pipelined_memory.sv
// -----------------------------------------------------------------------------
// pipelined_memory
// Handshaked data port (load/store, all MIPS widths incl. LWL/LWR/SWL/SWR)
// plus an instruction-fetch port over one byte-lane RAM.
//   req_*   : data request, accepted on req_valid && req_ready
//   resp_*  : one in-order response per accepted request, held while stalled
//   pc_*    : fetch port, data one cycle after pc_valid, no backpressure
// Optional feature macro: MEMORY_ALIGN_TRAP_EN -- misaligned HALFWORD/WORD
// accesses suppress the store and return resp_fault=1 with resp_data=0.
// Without it the misaligned low address bits are simply ignored.
// -----------------------------------------------------------------------------
module pipelined_memory
   import pipelined_memory_pkg::*;
#(
   parameter int    WORD_ADDR_BITS = 14,
   parameter string INIT_FILE      = ""
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [31:0]    req_address,
   input  logic [31:0]    req_data,
   input  ReadWriteMode_t req_write_mode,
   input  ReadWriteMode_t req_read_mode,
   input  logic           req_unsigned,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [31:0]    resp_data,
   output logic           resp_fault,
   input  logic           pc_valid,
   input  logic [31:0]    pc_address,
   output logic           pc_data_valid,
   output logic [31:0]    pc_data
);

   logic                      accept;
   logic                      faultNow;
   logic [1:0]                writeOffset;
   logic [1:0]                readOffset;
   logic [3:0]                storeLanes;
   logic [31:0]               storeWord;
   logic [WORD_ADDR_BITS-1:0] wordIndex;
   logic [WORD_ADDR_BITS-1:0] pcWordIndex;
   logic [31:0]               ramAData;
   logic [31:0]               ramBData;

   logic                      respValidReg;
   logic                      respFaultReg;
   logic                      respUnsignedReg;
   ReadWriteMode_t            respModeReg;
   logic [1:0]                respOffsetReg;

   logic                      pcDataValidReg;
   logic [3:0]                fwdMaskReg;
   logic [31:0]               fwdDataReg;
   logic [31:0]               pcMerged;
   logic [31:0]               shiftedDown;
   logic                      unusedAddrBits;

   assign req_ready   = !rst && !(respValidReg && !resp_ready);
   assign accept      = req_valid && req_ready;
   assign wordIndex   = req_address[WORD_ADDR_BITS+1:2];
   assign pcWordIndex = pc_address[WORD_ADDR_BITS+1:2];
   assign unusedAddrBits = ^{req_address[31:WORD_ADDR_BITS+2], pc_address[31:WORD_ADDR_BITS+2],
                             pc_address[1:0]};

`ifdef MEMORY_ALIGN_TRAP_EN
   assign faultNow = isMisaligned(req_write_mode, req_address[1:0]) ||
                     isMisaligned(req_read_mode, req_address[1:0]);
   assign resp_fault = respValidReg && respFaultReg;
`else
   assign faultNow   = 1'b0;
   assign resp_fault = 1'b0;
`endif

   // Store and load modes may differ, so each gets its own aligned offset.
   assign writeOffset = alignOffset(req_write_mode, req_address[1:0]);
   assign readOffset  = alignOffset(req_read_mode, req_address[1:0]);
   assign storeLanes  = (accept && !faultNow) ? laneMask(req_write_mode, writeOffset) : 4'b0000;
   assign storeWord   = storeShift(req_write_mode, writeOffset, req_data);

   // Port A only advances on accept, so the read word (and hence resp_data)
   // stays frozen during a response stall.
   pipelined_memory_byte_lane_ram #(
      .ADDR_BITS (WORD_ADDR_BITS),
      .INIT_FILE (INIT_FILE)
   ) ram (
      .clk          (clk),
      .aEnable      (accept),
      .aWriteEnable (storeLanes),
      .aAddress     (wordIndex),
      .aWriteData   (storeWord),
      .aReadData    (ramAData),
      .bAddress     (pcWordIndex),
      .bReadData    (ramBData)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         respValidReg    <= 1'b0;
         respFaultReg    <= 1'b0;
         respUnsignedReg <= 1'b0;
         respModeReg     <= ReadWriteMode_NONE;
         respOffsetReg   <= 2'b00;
         pcDataValidReg  <= 1'b0;
         fwdMaskReg      <= 4'b0000;
         fwdDataReg      <= 32'b0;
      end else begin
         if (accept) begin
            respValidReg    <= 1'b1;
            respFaultReg    <= faultNow;
            respUnsignedReg <= req_unsigned;
            respModeReg     <= req_read_mode;
            respOffsetReg   <= readOffset;
         end else if (resp_ready) begin
            respValidReg <= 1'b0;
         end
         pcDataValidReg <= pc_valid;
         // Fetch port reads the pre-store word; remember which lanes the
         // same-edge store changed so the fetch sees write-first data.
         fwdMaskReg <= (pc_valid && (pcWordIndex == wordIndex)) ? storeLanes : 4'b0000;
         fwdDataReg <= storeWord;
      end
   end

   assign shiftedDown = ramAData >> {respOffsetReg, 3'b000};

   always_comb begin
      resp_data = 32'b0;
      if (respValidReg && !respFaultReg) begin
         case (respModeReg)
            ReadWriteMode_BYTE:
               resp_data = respUnsignedReg ? {24'b0, shiftedDown[7:0]}
                                           : {{24{shiftedDown[7]}}, shiftedDown[7:0]};
            ReadWriteMode_HALFWORD:
               resp_data = respUnsignedReg ? {16'b0, shiftedDown[15:0]}
                                           : {{16{shiftedDown[15]}}, shiftedDown[15:0]};
            ReadWriteMode_WORD:      resp_data = ramAData;
            ReadWriteMode_WORDLEFT:  resp_data = ramAData << (5'd24 - {respOffsetReg, 3'b000});
            ReadWriteMode_WORDRIGHT: resp_data = shiftedDown;
            default:                 resp_data = 32'b0;
         endcase
      end
   end

   for (genvar gi = 0; gi < LANE_COUNT; gi++) begin : gPcLane
      assign pcMerged[8*gi +: 8] = fwdMaskReg[gi] ? fwdDataReg[8*gi +: 8] : ramBData[8*gi +: 8];
   end

   assign resp_valid    = respValidReg;
   assign pc_data_valid = pcDataValidReg;
   assign pc_data       = pcDataValidReg ? pcMerged : 32'b0;

endmodule
